booth_radix4_seq_mult: RTL and testbench

- Sequential radix-4 Booth multiplier; parametrised successor to the team's combinational Booth encoder and multiplier pair.
- Retires one Booth digit per cycle into an accumulator.
- Supports signed and unsigned operands, selected per operation.
- Valid/ready handshakes on both input and output; sits between operand-issue logic and result consumers in the arithmetic datapath.

---
 rtl/booth_pkg.sv | 46 ++++
 rtl/booth_pp_gen.sv | 33 +++
 rtl/booth_radix4_seq_mult.sv | 120 ++++++++++++
 tb/tb_booth_radix4_seq_mult.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// ============================================================================
// Module : booth_pkg
// Brief  : Shared types, digit-select encoding and radix-4 Booth decode.
// Rev    : 1.0 - initial sequential-multiplier release
// ============================================================================
`default_nettype none

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic nonzero;
    logic negative;
    logic twice;
  } booth_dig_t;

  // Digit-select code: low two bits pick the magnitude, NEG flags negation.
  typedef logic [2:0] sel_t;
  localparam sel_t ZERO = 3'b000;
  localparam sel_t PM1  = 3'b001;
  localparam sel_t PM2  = 3'b010;
  localparam sel_t NEG  = 3'b100;

  function automatic booth_dig_t booth_decode(input logic [2:0] grp);
    booth_dig_t d;
    d.nonzero  = (grp != 3'b000) && (grp != 3'b111);
    d.negative = grp[2] && d.nonzero;
    d.twice    = (grp == 3'b011) || (grp == 3'b100);
    return d;
  endfunction

  function automatic sel_t booth_sel(input booth_dig_t d);
    sel_t s;
    s = d.nonzero ? (d.twice ? PM2 : PM1) : ZERO;
    if (d.negative) s = s | NEG;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_pp_gen.sv
// ============================================================================
// Module : booth_pp_gen
// Brief  : Selects 0 / +-M / +-2M at accumulator width for one Booth digit.
// Rev    : 1.0 - initial sequential-multiplier release
// ============================================================================
`default_nettype none

module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int AW = 20
) (
  input  booth_dig_t      i_dig,
  input  logic [AW-1:0]   i_mcand,
  output logic [AW-1:0]   o_pp
);

  sel_t          w_sel;
  logic [AW-1:0] w_mag;

  always_comb begin
    w_sel = booth_sel(i_dig);
    case (w_sel & ~NEG)
      PM1:     w_mag = i_mcand;
      PM2:     w_mag = {i_mcand[AW-2:0], 1'b0};
      default: w_mag = '0;
    endcase
    o_pp = ((w_sel & NEG) != ZERO) ? (~w_mag + AW'(1)) : w_mag;
  end

endmodule

`default_nettype wire

// File: rtl/booth_radix4_seq_mult.sv
// ============================================================================
// Module : booth_radix4_seq_mult
// Brief  : Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready.
// Rev    : 1.0 - initial sequential-multiplier release
// ============================================================================
`default_nettype none

module booth_radix4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int NDIG  = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam int AW    = 2 * WIDTH + 4;
  localparam int BW    = WIDTH + 3;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(NDIG - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [AW-1:0]        r_acc;
  logic [AW-1:0]        r_mcand;
  logic [BW-1:0]        r_bvec;
  logic [2*WIDTH-1:0]   r_product;
  logic [AW-1:0]        w_pp;
  logic [AW-1:0]        w_sum;
  logic [WIDTH+1:0]     w_a_ext;
  logic [WIDTH+1:0]     w_b_ext;
  logic                 w_accept;
  logic                 w_last;
  booth_dig_t           w_dig;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == c_last);
  assign w_a_ext  = in_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
  assign w_b_ext  = in_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}     : {2'b00, multiplier};
  assign w_dig    = booth_decode(r_bvec[2:0]);
  assign w_sum    = r_acc + w_pp;

  booth_pp_gen #(.AW(AW)) u_pp_gen (
    .i_dig   (w_dig),
    .i_mcand (r_mcand),
    .o_pp    (w_pp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = CALC;
      CALC:    if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == CALC) || (r_state == DONE);
  end

  // Multiplicand walks left and Booth vector walks right, so digit k always
  // sits at bvec[2:0] with its weight 4^k already applied to the multiplicand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_bvec    <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand <= {{(AW-WIDTH-2){w_a_ext[WIDTH+1]}}, w_a_ext};
            r_bvec  <= {w_b_ext, 1'b0};
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        CALC: begin
          r_acc   <= w_sum;
          r_mcand <= {r_mcand[AW-3:0], 2'b00};
          r_bvec  <= {2'b00, r_bvec[BW-1:2]};
          if (w_last) begin
            r_cnt     <= '0;
            r_product <= w_sum[2*WIDTH-1:0];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_booth_radix4_seq_mult.sv
// ============================================================================
// Module : tb_booth_radix4_seq_mult
// Brief  : Directed self-checking bench for the WIDTH=8 Booth multiplier.
// Rev    : 1.0 - initial sequential-multiplier release
// ============================================================================
`default_nettype none

module tb_booth_radix4_seq_mult;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  int n_checks;
  int n_failures;

  booth_radix4_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_signed    (in_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction: accept, latency, result, optional backpressure, release.
  task automatic do_op(input string tag, input logic s, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp, input int stall);
    int          n;
    logic        rdy_seen;
    logic        stable_bad;
    logic [15:0] held;
    @(negedge clk);
    in_signed    = s;
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    out_ready    = 1'b0;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    in_signed    = ~s;
    multiplicand = ~a;
    multiplier   = ~b;
    rdy_seen = in_ready;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (in_ready) rdy_seen = 1'b1;
    end
    check_eq({tag, "_latency"}, n, 5);
    check_eq({tag, "_in_ready_low"}, {31'd0, rdy_seen}, 0);
    check_eq({tag, "_product"}, {16'd0, product}, {16'd0, exp});
    held = product;
    stable_bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!out_valid || in_ready || product !== held) stable_bad = 1'b1;
    end
    if (stall > 0) begin
      check_eq({tag, "_stall_stable"}, {31'd0, stable_bad}, 0);
      check_eq({tag, "_stall_product"}, {16'd0, product}, {16'd0, exp});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_release_valid"}, {31'd0, out_valid}, 0);
    check_eq({tag, "_release_ready"}, {31'd0, in_ready}, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    n_checks     = 0;
    n_failures   = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_signed    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_in_ready", {31'd0, in_ready}, 1);
    check_eq("reset_out_valid", {31'd0, out_valid}, 0);
    check_eq("reset_busy", {31'd0, busy}, 0);
    check_eq("reset_product", {16'd0, product}, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op("u5x3",      1'b0, 8'd5,   8'd3,   16'h000F, 0);
    do_op("u255x255",  1'b0, 8'hFF,  8'hFF,  16'hFE01, 0);
    do_op("s-128x-128",1'b1, 8'h80,  8'h80,  16'h4000, 0);
    do_op("s-1x127",   1'b1, 8'hFF,  8'h7F,  16'hFF81, 0);
    do_op("s127x-128", 1'b1, 8'h7F,  8'h80,  16'hC080, 4);
    do_op("s-3x5",     1'b1, 8'hFD,  8'h05,  16'hFFF1, 0);
    do_op("u128x2",    1'b0, 8'h80,  8'h02,  16'h0100, 0);

    // Abort mid-calculation with an asynchronous reset pulse.
    @(negedge clk);
    in_signed = 1'b0; multiplicand = 8'd200; multiplier = 8'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_out_valid", {31'd0, out_valid}, 0);
    check_eq("abort_in_ready", {31'd0, in_ready}, 1);
    check_eq("abort_product", {16'd0, product}, 0);
    check_eq("abort_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op("u10x10", 1'b0, 8'd10, 8'd10, 16'd100, 0);

    // Back-to-back with out_ready tied high.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_signed = 1'b0;
    multiplicand = 8'd0; multiplier = 8'd255;
    @(posedge clk); #1;
    multiplicand = 8'd1; multiplier = 8'd127;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("b2b_first_latency", n, 5);
    check_eq("b2b_first_product", {16'd0, product}, 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(busy && !out_valid) && n < 10);
    check_eq("b2b_accept_gap", n, 2);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("b2b_second_latency", n, 5);
    check_eq("b2b_second_product", {16'd0, product}, 127);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b_idle", {31'd0, in_ready}, 1);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

`default_nettype wire
